// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, colour type and the fixed 4-bit index to 12-bit RGB map.
package vga_pkg;

    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

    localparam int CNT_W  = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);
    localparam int ADDR_W = $clog2(FB_DEPTH);
    localparam int X_W    = $clog2(FB_WIDTH);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // One channel of the fixed map: c selects the colour, i is the intensity bit.
    function automatic logic [3:0] channel_level(input logic c, input logic i);
        if (c) return i ? 4'hF : 4'hA;
        else   return i ? 4'h5 : 4'h0;
    endfunction

    function automatic rgb12_t default_color(input logic [3:0] idx);
        rgb12_t col;
        col.r = channel_level(idx[2], idx[3]);
        col.g = channel_level(idx[1], idx[3]);
        col.b = channel_level(idx[0], idx[3]);
        return col;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v raster counters and the stage-0 decodes
// (visible area, sync windows, frame origin).
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic             vga_clk,
    input  logic             vga_rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs,
    output logic             vs,
    output logic             origin
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    // Next raster position: v advances on the same edge that h wraps.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Counter registers, cleared by synchronous reset.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;
    assign active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hs     = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs     = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    assign origin = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480 VGA scanout of a 320x240 4bpp frame buffer with 2x pixel
// doubling. Read address is combinational from the counters; sync, blank, colour
// and frame_start leave two registers later, mutually aligned.
// Optional: define VGA_SCANOUT_PALETTE_EN for a writable 16x12 palette.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic              vga_clk,
    input  logic              vga_rst,
    output logic [ADDR_W-1:0] vga_pixel_addr,
    input  logic [3:0]        vga_pixel_data,
`ifdef VGA_SCANOUT_PALETTE_EN
    input  logic              pal_we,
    input  logic [3:0]        pal_addr,
    input  logic [11:0]       pal_data,
`endif
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank,
    output logic              frame_start
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             active, hs, vs, origin;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
    ) u_timing (
        .vga_clk (vga_clk),
        .vga_rst (vga_rst),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .active  (active),
        .hs      (hs),
        .vs      (vs),
        .origin  (origin)
    );

    logic [X_W-1:0]    x_pix;
    logic [ADDR_W-1:0] y_ext;

    // Halve both counters and form y*320 + x as (y<<8)+(y<<6)+x; zero outside the visible area.
    always_comb begin
        x_pix          = h_cnt[CNT_W-1:1];
        y_ext          = ADDR_W'(v_cnt[CNT_W-1:1]);
        vga_pixel_addr = '0;
        if (active) vga_pixel_addr = (y_ext << 8) + (y_ext << 6) + ADDR_W'(x_pix);
    end

    logic   s1_active_q, s1_active_d;
    logic   s1_hs_q, s1_hs_d;
    logic   s1_vs_q, s1_vs_d;
    logic   s1_origin_q, s1_origin_d;
    rgb12_t rgb_q, rgb_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   blank_q, blank_d;
    logic   frame_start_q, frame_start_d;
    rgb12_t lookup;

`ifdef VGA_SCANOUT_PALETTE_EN
    rgb12_t pal_q [16];
    rgb12_t pal_d [16];

    // Palette write; a same-cycle lookup still sees the stored (old) entry.
    always_comb begin
        for (int i = 0; i < 16; i++) pal_d[i] = pal_q[i];
        if (pal_we) pal_d[pal_addr] = rgb12_t'(pal_data);
    end

    // Palette registers, reloaded with the fixed map on reset.
    always_ff @(posedge vga_clk) begin
        for (int i = 0; i < 16; i++) begin
            if (vga_rst) pal_q[i] <= default_color(4'(i));
            else         pal_q[i] <= pal_d[i];
        end
    end

    assign lookup = pal_q[vga_pixel_data];
`else
    assign lookup = default_color(vga_pixel_data);
`endif

    // Stage-1 follows the decodes while the frame buffer read completes; stage-2 forms the pins.
    always_comb begin
        s1_active_d   = active;
        s1_hs_d       = hs;
        s1_vs_d       = vs;
        s1_origin_d   = origin;
        rgb_d         = s1_active_q ? lookup : '0;
        hsync_d       = ~s1_hs_q;
        vsync_d       = ~s1_vs_q;
        blank_d       = ~s1_active_q;
        frame_start_d = s1_origin_q;
    end

    // Pipeline registers; syncs idle high and blank is asserted during reset.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            s1_active_q   <= 1'b0;
            s1_hs_q       <= 1'b0;
            s1_vs_q       <= 1'b0;
            s1_origin_q   <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            s1_active_q   <= s1_active_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            s1_origin_q   <= s1_origin_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank   = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench. Horizontal timing is the full 800-pixel line;
// the frame is shortened vertically (40 visible lines) so whole frames fit a short run.
`timescale 1ns/1ps
module tb_vga_scanout;

    localparam int VV = 40, VF = 3, VS = 2, VB = 5;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = 800 * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] addr;
    logic [3:0]  fb_data;
    logic [3:0]  r, g, b;
    logic        hsync, vsync, blank, fstart;
    logic [11:0] rgb_o;
    logic        fb_force;
    logic [3:0]  fb_val;
`ifdef VGA_SCANOUT_PALETTE_EN
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_data;
`endif

    always #20 clk = ~clk;

    vga_scanout #(
        .H_VISIBLE (640), .H_FRONT (16), .H_SYNC (96), .H_BACK (48),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .vga_clk        (clk),
        .vga_rst        (rst),
        .vga_pixel_addr (addr),
        .vga_pixel_data (fb_data),
`ifdef VGA_SCANOUT_PALETTE_EN
        .pal_we         (pal_we),
        .pal_addr       (pal_addr),
        .pal_data       (pal_data),
`endif
        .vga_r          (r),
        .vga_g          (g),
        .vga_b          (b),
        .vga_hsync      (hsync),
        .vga_vsync      (vsync),
        .vga_blank      (blank),
        .frame_start    (fstart)
    );

    assign rgb_o = {r, g, b};

    // Frame buffer model: registered read, pixel[a] = a[3:0] unless overridden.
    always @(posedge clk) fb_data <= fb_force ? fb_val : addr[3:0];

    int n = 0, total = 0, passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task step();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    function automatic logic [3:0] lvl(input logic c, input logic i);
        case ({c, i})
            2'b00:   return 4'h0;
            2'b01:   return 4'h5;
            2'b10:   return 4'hA;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [11:0] exp_rgb(input logic [3:0] idx);
        return {lvl(idx[2], idx[3]), lvl(idx[1], idx[3]), lvl(idx[0], idx[3])};
    endfunction

    int p, h, v, q, qh, qv, fa, ea;
    logic vis, e_hs, e_vs;
    logic [11:0] e_rgb;
    int hs_mis = 0, vs_mis = 0, bl_mis = 0, rgb_mis = 0, fs_mis = 0, addr_mis = 0, l23_mis = 0;
    int addr_max = 0, fs_cnt = 0, fs_n2 = -1, hs0_low = 0, first_hs_n = -1;
    int rgb00 = -1, rgb10 = -1, rgb20 = -1, blank20 = -1, rgb_last = -1, addr_last = -1;
    int line2 [800];

    initial begin
        rst = 1'b1; fb_force = 1'b0; fb_val = 4'h0;
`ifdef VGA_SCANOUT_PALETTE_EN
        pal_we = 1'b0; pal_addr = 4'h0; pal_data = 12'h000;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hsync", hsync, 1);
        check("reset_vsync", vsync, 1);
        check("reset_blank", blank, 1);
        check("reset_rgb", rgb_o, 0);
        check("reset_frame_start", fstart, 0);
        check("reset_addr", addr, 0);

        rst = 1'b0;
        n = 0;
        step();
        check("fs_release_plus1", fstart, 0);
        step();
        check("fs_release_plus2", fstart, 1);

        // One full frame plus the next frame_start, scoring every cycle against the raster model.
        for (int k = 0; k < FRAME + 2; k++) begin
            p = (n - 2) % FRAME; h = p % 800; v = p / 800;
            vis  = (h < 640) && (v < VV);
            e_hs = !((h >= 656) && (h < 752));
            e_vs = !((v >= VV + VF) && (v < VV + VF + VS));
            fa   = (v / 2) * 320 + h / 2;
            e_rgb = vis ? exp_rgb(fa[3:0]) : 12'h000;
            if (hsync !== e_hs)  hs_mis++;
            if (vsync !== e_vs)  vs_mis++;
            if (blank !== !vis)  bl_mis++;
            if (rgb_o !== e_rgb) rgb_mis++;
            if (fstart !== (p == 0)) fs_mis++;
            if (fstart) begin
                fs_cnt++;
                if (fs_cnt == 2) fs_n2 = n;
            end
            if ((n - 2) < 800 && !hsync) begin
                hs0_low++;
                if (first_hs_n < 0) first_hs_n = n;
            end
            if (p == 0) rgb00 = int'(rgb_o);
            if (p == 1) rgb10 = int'(rgb_o);
            if (p == 2) begin rgb20 = int'(rgb_o); blank20 = int'(blank); end
            if (p == (VV - 1) * 800 + 639) rgb_last = int'(rgb_o);

            q = n % FRAME; qh = q % 800; qv = q / 800;
            ea = ((qh < 640) && (qv < VV)) ? (qv / 2) * 320 + qh / 2 : 0;
            if (int'(addr) != ea) addr_mis++;
            if (int'(addr) > addr_max) addr_max = int'(addr);
            if (q == (VV - 1) * 800 + 639) addr_last = int'(addr);
            if (n < FRAME && qv == 2) line2[qh] = int'(addr);
            if (n < FRAME && qv == 3 && int'(addr) != line2[qh]) l23_mis++;
            step();
        end

        check("hsync_mismatches", hs_mis, 0);
        check("vsync_mismatches", vs_mis, 0);
        check("blank_mismatches", bl_mis, 0);
        check("rgb_mismatches", rgb_mis, 0);
        check("frame_start_mismatches", fs_mis, 0);
        check("addr_mismatches", addr_mis, 0);
        check("addr_max_bound", (addr_max <= 76799), 1);
        check("frame_start_count", fs_cnt, 2);
        check("frame_period", fs_n2 - 2, FRAME);
        check("hsync_first_low_cycle", first_hs_n, 658);
        check("hsync_low_width_line0", hs0_low, 96);
        check("line2_line3_addr_equal", l23_mis, 0);
        check("pix_0_0_rgb", rgb00, 0);
        check("pix_1_0_rgb", rgb10, 0);
        check("pix_2_0_rgb", rgb20, 12'h00A);
        check("pix_2_0_blank", blank20, 0);
        check("last_pixel_addr", addr_last, ((VV - 1) / 2) * 320 + 319);
        check("last_pixel_rgb", rgb_last, 12'hFFF);

        // Index C in and outside the visible area.
        fb_force = 1'b1; fb_val = 4'hC;
        step(); step();
        check("idx_c_visible_rgb", rgb_o, 12'hF55);
        check("idx_c_visible_blank", blank, 0);
        while ((n - 2) % FRAME != 700) step();
        check("idx_c_blanked_rgb", rgb_o, 12'h000);
        check("idx_c_blanked_blank", blank, 1);
        fb_force = 1'b0;

        // Reset pulse with the counters at (300,20).
        while (n % FRAME != 20 * 800 + 300) step();
        check("pre_reset_addr", addr, 10 * 320 + 150);
        check("pre_reset_rgb", rgb_o, 12'hA0A);
        rst = 1'b1;
        step();
        check("mid_reset_addr", addr, 0);
        check("mid_reset_hsync", hsync, 1);
        check("mid_reset_vsync", vsync, 1);
        check("mid_reset_blank", blank, 1);
        check("mid_reset_rgb", rgb_o, 0);
        check("mid_reset_fs", fstart, 0);
        rst = 1'b0;
        n = 0;
        step();
        check("mid_release_fs_plus1", fstart, 0);
        step();
        check("mid_release_fs_plus2", fstart, 1);
        check("mid_release_addr_plus2", addr, 1);

`ifdef VGA_SCANOUT_PALETTE_EN
        pal_we = 1'b1; pal_addr = 4'h3; pal_data = 12'h123;
        fb_force = 1'b1; fb_val = 4'h3;
        step();
        pal_we = 1'b0;
        step();
        check("palette_written_idx3", rgb_o, 12'h123);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        step(); step();
        check("palette_reset_idx3", rgb_o, 12'h0AA);
        check("palette_reset_blank", blank, 0);
        fb_force = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
